background_fetch: RTL and testbench

BACKGROUND_FETCH -- requirements
Module: background_fetch

---
 rtl/bg_pkg.sv | 32 +++
 rtl/bg_skid_buf.sv | 55 +++++
 rtl/background_fetch.sv | 159 +++++++++++++++
 tb/tb_background_fetch.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// Shared definitions for the background line fetcher: geometry defaults,
// bus widths, the FSM state encoding and the constant-multiplier helper.
package bg_pkg;

    localparam int LINE_W_DEF    = 640;
    localparam int NUM_LINES_DEF = 480;
    localparam int ADDR_W        = 19;
    localparam int PIX_W         = 4;
    localparam int X_W           = 10;
    localparam int Y_W           = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } bg_state_e;

    // y * lw built only from shifted copies of y, one per set bit of the
    // constant lw (for 640 this is (y << 9) + (y << 7)).
    function automatic logic [ADDR_W-1:0] line_base(input logic [Y_W-1:0] y,
                                                    input int lw);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < X_W + 1; i++) begin
            if (lw[i]) begin
                acc = acc + (ADDR_W'(y) << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/bg_skid_buf.sv
// Two-entry output buffer between the ROM return path and the pixel consumer.
// Handshake (both sides): a word moves on a rising edge exactly when valid and
// ready are both high; a producer holding valid keeps its data stable until it
// moves; ready never depends combinationally on valid.
module bg_skid_buf
    import bg_pkg::*;
#(
    parameter int W = X_W + PIX_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign o_ready = (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    // Storage, pointers and occupancy; cleared so the outputs read zero in reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/background_fetch.sv
// Background line fetcher: on start, streams one image line out of a
// synchronous background ROM as (pix_x, pix_data) on a valid/ready port.
// Optional horizontal scrolling is compiled in with BG_SCROLL_EN.
// Pipeline: address register -> ROM output register -> 2-entry skid buffer.
// The ROM output register doubles as a third slot: while no new address is
// issued, rom_addr holds and the ROM keeps returning the same word.
module background_fetch
    import bg_pkg::*;
#(
    parameter int LINE_W    = LINE_W_DEF,
    parameter int NUM_LINES = NUM_LINES_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [Y_W-1:0]    line_y,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic [X_W-1:0]    pix_x,
`ifdef BG_SCROLL_EN
    input  logic [X_W-1:0]    scroll_x,
`endif
    output bg_state_e         o_dbg_state
);

    bg_state_e         r_state;
    bg_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [X_W-1:0]    r_issue_x;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_av;
    logic [X_W-1:0]    r_av_x;
    logic              r_dv;
    logic [X_W-1:0]    r_dv_x;
    logic              r_done;
    logic [X_W-1:0]    w_src_x;
    logic              w_accept;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_last_pop;
    logic              w_push;
    logic              w_pop;
    logic              w_buf_ready;
    logic [1:0]        w_buf_count;
    logic [1:0]        w_cnt_nxt;
    logic              w_dv_nxt;
    logic              w_credit;

    assign w_accept     = (r_state == ST_IDLE) && start && (int'(line_y) < NUM_LINES);
    assign w_last_issue = (r_issue_x == X_W'(LINE_W - 1));
    assign w_push       = r_dv && w_buf_ready;
    assign w_pop        = pix_valid && pix_ready;
    assign w_last_pop   = (r_state == ST_DRAIN) && w_pop && (pix_x == X_W'(LINE_W - 1));

    // Credit: occupancy after this edge, plus the word that will sit at the ROM
    // output, must leave room so the returning word can always be pushed.
    assign w_cnt_nxt = w_buf_count + {1'b0, w_push} - {1'b0, w_pop};
    assign w_dv_nxt  = r_av || (r_dv && !w_push);
    assign w_credit  = !w_dv_nxt || (w_cnt_nxt != 2'd2);
    assign w_issue   = (r_state == ST_FETCH) && w_credit;

`ifdef BG_SCROLL_EN
    logic [X_W-1:0] r_src_x;
    logic [X_W-1:0] w_scroll_mod;

    // A single subtraction reduces scroll_x into range for LINE_W > 511.
    assign w_scroll_mod = (scroll_x >= X_W'(LINE_W)) ? (scroll_x - X_W'(LINE_W)) : scroll_x;
    assign w_src_x      = r_src_x;

    // Source column walks from the scroll offset and wraps inside the line.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_src_x <= '0;
        end else if (w_accept) begin
            r_src_x <= w_scroll_mod;
        end else if (w_issue) begin
            r_src_x <= (r_src_x == X_W'(LINE_W - 1)) ? '0 : (r_src_x + X_W'(1));
        end
    end
`else
    assign w_src_x = r_issue_x;
`endif

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: fetch until the last address issues, then drain.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)                 w_state_nxt = ST_FETCH;
            ST_FETCH: if (w_issue && w_last_issue)  w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_last_pop)               w_state_nxt = ST_IDLE;
            default:                                w_state_nxt = ST_IDLE;
        endcase
    end

    // Address generation and the two in-flight stages that tag ROM words with x.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_base     <= '0;
            r_issue_x  <= '0;
            r_rom_addr <= '0;
            r_av       <= 1'b0;
            r_av_x     <= '0;
            r_dv       <= 1'b0;
            r_dv_x     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last_pop;
            if (w_accept) begin
                r_base    <= line_base(line_y, LINE_W);
                r_issue_x <= '0;
            end else if (w_issue) begin
                r_issue_x <= r_issue_x + X_W'(1);
            end
            if (w_issue) begin
                r_rom_addr <= r_base + ADDR_W'(w_src_x);
                r_av_x     <= r_issue_x;
            end
            r_av <= w_issue;
            r_dv <= w_dv_nxt;
            if (r_av) begin
                r_dv_x <= r_av_x;
            end
        end
    end

    bg_skid_buf #(
        .W (X_W + PIX_W)
    ) u_skid (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_valid (r_dv),
        .o_ready (w_buf_ready),
        .i_data  ({r_dv_x, rom_data}),
        .o_valid (pix_valid),
        .i_ready (pix_ready),
        .o_data  ({pix_x, pix_data}),
        .o_count (w_buf_count)
    );

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign rom_addr    = r_rom_addr;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_background_fetch.sv
// Directed bench for background_fetch with a synchronous ROM model and a
// pixel scoreboard; define BG_SCROLL_EN to include the scrolling case.
module tb_background_fetch;
    import bg_pkg::*;

    logic              Clk;
    logic              Reset_n;
    logic              start;
    logic [Y_W-1:0]    line_y;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rom_addr;
    logic [PIX_W-1:0]  rom_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [PIX_W-1:0]  pix_data;
    logic [X_W-1:0]    pix_x;
    bg_state_e         dbg_state;
`ifdef BG_SCROLL_EN
    logic [X_W-1:0]    scroll_x;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_edge = 0;
    int n_xfer = 0;
    int n_done = 0;
    int done_cyc = 0;
    int line_a = 0;
    int x0 = 0;
    int n0 = 0;

    logic [X_W+PIX_W-1:0] exp_q[$];
    logic [X_W+PIX_W-1:0] exp_e;
    logic                 prev_stall = 1'b0;
    logic [X_W-1:0]       prev_x = '0;
    logic [PIX_W-1:0]     prev_data = '0;

    background_fetch dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .start       (start),
        .line_y      (line_y),
        .busy        (busy),
        .done        (done),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
`ifdef BG_SCROLL_EN
        .scroll_x    (scroll_x),
`endif
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- ROM model ----------------
    function automatic logic [PIX_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {1'b0, a[18:16]};
    endfunction

    initial rom_data = '0;
    always @(posedge Clk) rom_data <= rom_f(rom_addr);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected pixels of one line, in screen-x order.
    task automatic push_line(input int y, input int s);
        int a;
        for (int x = 0; x < 640; x++) begin
            a = y * 640 + ((x + s) % 640);
            exp_q.push_back({X_W'(x), rom_f(ADDR_W'(a))});
        end
    endtask

    // Scoreboard: every transfer is compared, stalled outputs must not move.
    always @(negedge Clk) begin
        if (!Reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", pix_valid, 1);
                check("stall_x", pix_x, prev_x);
                check("stall_data", pix_data, prev_data);
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    check("pix_extra", exp_q.size(), 1);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("pix_x", pix_x, exp_e[X_W+PIX_W-1:PIX_W]);
                    check("pix_data", pix_data, exp_e[PIX_W-1:0]);
                end
                n_xfer++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_x     = pix_x;
            prev_data  = pix_data;
        end
    end

    // ---------------- driver tasks ----------------
    // Call just after a rising edge; returns at the falling edge of cycle 0.
    task automatic do_start(input int y);
        start  = 1'b1;
        line_y = Y_W'(y);
        @(posedge Clk);
        #1;
        start_edge = cyc;
        start      = 1'b0;
        @(negedge Clk);
    endtask

    task automatic goto_cyc(input int k);
        while (cyc < start_edge + k) @(negedge Clk);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base_n;
        base_n = n_done;
        for (int i = 0; i < budget && n_done == base_n; i++) @(negedge Clk);
        check(tag, n_done, base_n + 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        Reset_n   = 1'b0;
        start     = 1'b0;
        line_y    = '0;
        pix_ready = 1'b0;
`ifdef BG_SCROLL_EN
        scroll_x  = '0;
`endif
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", pix_valid, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_data", pix_data, 0);
        check("rst_x", pix_x, 0);
        check("rst_state", dbg_state, ST_IDLE);
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        repeat (4) @(negedge Clk);
        check("quiet_valid", pix_valid, 0);
        check("quiet_addr", rom_addr, 0);
        check("quiet_busy", busy, 0);

        // Line 0 at full rate, then line 3 started in the done cycle.
        pix_ready = 1'b1;
        push_line(0, 0);
        @(posedge Clk);
        #1 do_start(0);
        line_a = start_edge;
        check("l0_busy_c0", busy, 1);
        goto_cyc(1); check("l0_addr_c1", rom_addr, 0);
        goto_cyc(2); check("l0_addr_c2", rom_addr, 1);
        check("l0_valid_c2", pix_valid, 0);
        goto_cyc(3); check("l0_valid_c3", pix_valid, 1);
        check("l0_x_c3", pix_x, 0);
        goto_cyc(640); check("l0_addr_c640", rom_addr, 639);
        goto_cyc(642); check("l0_x_c642", pix_x, 639);
        push_line(3, 0);
        @(posedge Clk);
        #1;
        check("l0_done_c643", done, 1);
        check("l0_busy_c643", busy, 0);
        do_start(3);
        check("l0_done_cycle", done_cyc - line_a, 643);
        check("l3_busy_c0", busy, 1);
        goto_cyc(3); check("l3_valid_c3", pix_valid, 1);
        check("l3_x_c3", pix_x, 0);
        goto_cyc(641); check("l3_addr_hold", rom_addr, 2559);
        wait_done("l3_done_seen", 50);
        check("l3_done_cycle", done_cyc - start_edge, 643);
        check("l0l3_xfers", n_xfer, 1280);
        check("l0l3_queue", exp_q.size(), 0);

        // Last line of the image, then an out-of-range line.
        push_line(479, 0);
        @(posedge Clk);
        #1 do_start(479);
        goto_cyc(1); check("l479_first_addr", rom_addr, 306560);
        goto_cyc(640); check("l479_last_addr", rom_addr, 307199);
        wait_done("l479_done_seen", 50);
        check("l479_done_cycle", done_cyc - start_edge, 643);
        n0 = n_done;
        @(posedge Clk);
        #1 do_start(480);
        check("l480_busy_c0", busy, 0);
        check("l480_state", dbg_state, ST_IDLE);
        repeat (8) @(negedge Clk);
        check("l480_busy_late", busy, 0);
        check("l480_addr_hold", rom_addr, 307199);
        check("l480_valid", pix_valid, 0);
        check("l480_no_done", n_done, n0);

        // Line 5 under random backpressure with a 20-cycle stall and a
        // start request while busy.
        push_line(5, 0);
        x0 = n_xfer;
        n0 = n_done;
        @(posedge Clk);
        #1 do_start(5);
        for (int c = 0; c < 5000 && n_done == n0; c++) begin
            @(posedge Clk);
            #1;
            pix_ready = (c >= 40 && c < 60) ? 1'b0 : 1'($urandom_range(0, 1));
            start     = (c == 15);
            line_y    = Y_W'(7);
        end
        start = 1'b0;
        check("l5_done_seen", n_done, n0 + 1);
        check("l5_xfers", n_xfer - x0, 640);
        check("l5_queue", exp_q.size(), 0);
        pix_ready = 1'b1;
        repeat (4) @(negedge Clk);
        check("l5_idle_after", busy, 0);

        // Reset while pixel 300 of line 2 is presented, then a clean line 10.
        push_line(2, 0);
        @(posedge Clk);
        #1 do_start(2);
        goto_cyc(303); check("l2_x_c303", pix_x, 300);
        #2 Reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_valid", pix_valid, 0);
        check("mid_rst_addr", rom_addr, 0);
        check("mid_rst_data", pix_data, 0);
        check("mid_rst_x", pix_x, 0);
        check("mid_rst_state", dbg_state, ST_IDLE);
        exp_q.delete();
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        repeat (4) @(negedge Clk);
        check("post_rst_valid", pix_valid, 0);
        check("post_rst_addr", rom_addr, 0);
        push_line(10, 0);
        x0 = n_xfer;
        @(posedge Clk);
        #1 do_start(10);
        goto_cyc(1); check("l10_addr_c1", rom_addr, 6400);
        goto_cyc(3); check("l10_x_c3", pix_x, 0);
        wait_done("l10_done_seen", 700);
        check("l10_done_cycle", done_cyc - start_edge, 643);
        check("l10_xfers", n_xfer - x0, 640);
        check("l10_queue", exp_q.size(), 0);

`ifdef BG_SCROLL_EN
        // Scrolled line 1: screen x=0 reads column 630, x=10 wraps to column 0.
        scroll_x = 10'd630;
        push_line(1, 630);
        @(posedge Clk);
        #1 do_start(1);
        goto_cyc(1); check("scr_addr_x0", rom_addr, 1270);
        goto_cyc(11); check("scr_addr_x10", rom_addr, 640);
        goto_cyc(13); check("scr_pix_x10", pix_x, 10);
        wait_done("scr_done_seen", 700);
        check("scr_queue", exp_q.size(), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
